md_unit: RTL and testbench

Multi-cycle integer multiply/divide unit owning the HI/LO register pair for the MIPS core. It sits in the EX stage and accepts MULT/MULTU/DIV/DIVU operations plus MTHI/MTLO writes. It produces the `busy` flag that the pipeline stall controller combines with its HI/LO-access decode to freeze IF/ID. It aborts cleanly on exception or ERET flush from MEM.

---
 rtl/md_unit.sv | 189 ++++++++++++++++++
 tb/tb_md_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair.
// Multiply completes after MUL_LAT busy cycles; divide runs DIV_ITER restoring
// iterations followed by a sign-fixup cycle. A flush from MEM aborts any
// in-flight operation without touching HI/LO.
module md_unit #(
  parameter int unsigned MUL_LAT  = 4,
  parameter int unsigned DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_signed;
  logic [W-1:0]     op_a;
  logic [W-1:0]     mul_b;
  logic [W-1:0]     dvsr;
  logic [W-1:0]     quo;
  logic [W-1:0]     rem;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  // Operand magnitudes at issue time (signed ops only take absolute values).
  logic             issue_signed;
  logic [W-1:0]     abs_a;
  logic [W-1:0]     abs_b;

  always_comb begin
    issue_signed = ~op[0];
    abs_a        = (issue_signed && src_a[W-1]) ? (W'(0) - src_a) : src_a;
    abs_b        = (issue_signed && src_b[W-1]) ? (W'(0) - src_b) : src_b;
  end

  // 64-bit product of the latched operands, sign- or zero-extended.
  logic [2*W-1:0] ext_a;
  logic [2*W-1:0] ext_b;
  logic [2*W-1:0] product;

  always_comb begin
    ext_a   = op_signed ? {{W{op_a[W-1]}}, op_a}   : {{W{1'b0}}, op_a};
    ext_b   = op_signed ? {{W{mul_b[W-1]}}, mul_b} : {{W{1'b0}}, mul_b};
    product = ext_a * ext_b;
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  logic [W:0]   rem_shift;
  logic         take;
  logic [W-1:0] rem_next;
  logic [W-1:0] quo_next;

  always_comb begin
    rem_shift = {rem, quo[W-1]};
    take      = (rem_shift >= {1'b0, dvsr});
    rem_next  = take ? (rem_shift[W-1:0] - dvsr) : rem_shift[W-1:0];
    quo_next  = {quo[W-2:0], take};
  end

  // Sign-corrected divide result; divide-by-zero bypasses the fixup.
  logic [W-1:0] q_fix;
  logic [W-1:0] r_fix;

  always_comb begin
    q_fix = neg_q ? (W'(0) - quo) : quo;
    r_fix = neg_r ? (W'(0) - rem) : rem;
    if (div_zero) begin
      q_fix = '1;
      r_fix = op_a;
    end
  end

  // Control FSM with registered busy/HI/LO and operand/iteration state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      op_signed <= 1'b0;
      op_a      <= '0;
      mul_b     <= '0;
      dvsr      <= '0;
      quo       <= '0;
      rem       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!flush) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
            if (start) begin
              op_signed <= issue_signed;
              op_a      <= src_a;
              mul_b     <= src_b;
              dvsr      <= abs_b;
              quo       <= abs_a;
              rem       <= '0;
              neg_q     <= issue_signed & (src_a[W-1] ^ src_b[W-1]);
              neg_r     <= issue_signed & src_a[W-1];
              div_zero  <= (src_b == '0);
              cnt       <= '0;
              busy      <= 1'b1;
              state     <= op[1] ? S_DIV : S_MUL;
            end
          end
        end

        S_MUL: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == MUL_LAST) begin
            hi    <= product[2*W-1:W];
            lo    <= product[W-1:0];
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            if (cnt == DIV_LAST) begin
              state <= S_FIX;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        S_FIX: begin
          if (!flush) begin
            hi <= r_fix;
            lo <= q_fix;
          end
          state <= S_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO and busy length,
// a monitor pops and compares on every falling edge of busy.
module tb_md_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  md_unit #(.MUL_LAT(4), .DIV_ITER(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: measure each busy window and compare HI/LO when it closes.
  initial begin
    logic prev;
    int   run;
    exp_t e;
    prev = 1'b0;
    run  = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        run++;
      end else begin
        if (prev === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: busy fell after %0d cycles with no expected result", run);
          end else begin
            e = sb.pop_front();
            check("sb_hi", hi, e.hi);
            check("sb_lo", lo, e.lo);
            check("sb_busy_cycles", 32'(run), 32'(e.cyc));
          end
        end
        run = 0;
      end
      prev = busy;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL timeout: busy still 0x%0h after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic push(input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
    exp_t e;
    e.hi  = ehi;
    e.lo  = elo;
    e.cyc = ecyc;
    sb.push_back(e);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
    push(ehi, elo, ecyc);
    @(posedge clk);
    #1;
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b1;
    op    = OP_MULT;
    src_a = 32'd3;
    src_b = 32'd3;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    flush = 1'b0;

    // Reset held with start asserted: nothing accepted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    start = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    check("rst_no_accept", 32'(busy), 32'd0);

    // Multiply variants.
    do_op(OP_MULT,  32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 4);
    do_op(OP_MULTU, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB, 4);
    do_op(OP_MULT,  32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000, 4);
    do_op(OP_MULTU, 32'h80000000, 32'd1, 32'h00000000, 32'h80000000, 4);

    // Divide variants, including overflow and divide-by-zero.
    do_op(OP_DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       33);
    do_op(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    do_op(OP_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33);
    do_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33);
    do_op(OP_DIVU, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 33);
    do_op(OP_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 33);

    // MTHI / MTLO preload, then flush a divide on busy cycle 10.
    @(posedge clk);
    #1;
    hi_we = 1'b1;
    wdata = 32'h0000AAAA;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b1;
    wdata = 32'h00005555;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    check("mthi", hi, 32'h0000AAAA);
    check("mtlo", lo, 32'h00005555);

    push(32'h0000AAAA, 32'h00005555, 10);
    op    = OP_DIV;
    src_a = 32'd100;
    src_b = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("flush_hi_kept", hi, 32'h0000AAAA);
    check("flush_lo_kept", lo, 32'h00005555);
    do_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);

    // start and hi_we pulsed while busy are both ignored.
    push(32'd0, 32'd15, 4);
    @(posedge clk);
    #1;
    op    = OP_MULTU;
    src_a = 32'd3;
    src_b = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    op    = OP_DIV;
    src_a = 32'd100;
    src_b = 32'd7;
    start = 1'b1;
    hi_we = 1'b1;
    wdata = 32'h0000DEAD;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    wdata = '0;
    wait_idle();
    @(posedge clk);
    #1;
    check("busy_start_ignored", 32'(busy), 32'd0);
    check("busy_hi_we_ignored", hi, 32'd0);

    // start + flush in IDLE: not accepted.
    op    = OP_MULT;
    src_a = 32'd9;
    src_b = 32'd9;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("start_flush_busy0", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("start_flush_busy1", 32'(busy), 32'd0);
    check("start_flush_lo", lo, 32'd15);

    // start with both MTHI/MTLO strobes in IDLE: write lands, result overwrites later.
    push(32'd0, 32'd6, 4);
    op    = OP_MULT;
    src_a = 32'd2;
    src_b = 32'd3;
    start = 1'b1;
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h00001111;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("coincident_hi", hi, 32'h00001111);
    check("coincident_lo", lo, 32'h00001111);
    check("coincident_busy", 32'(busy), 32'd1);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
